// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader: byte stream to big-endian 32-bit imem words, core held in reset until done
module imem_loader #(
  parameter int IMEM_DEPTH  = 256,
  parameter int IMEM_ADDR_W = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   core_rst,
  output logic                   load_done,
  output logic                   load_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t                 state_q;
  logic [15:0]            count_q;
  logic [15:0]            word_cnt_q;
  logic [1:0]             byte_cnt_q;
  logic [23:0]            asm_q;
  logic                   rx_ready_q;
  logic                   imem_we_q;
  logic [IMEM_ADDR_W-1:0] imem_addr_q;
  logic [31:0]            imem_wdata_q;
  logic                   core_rst_q;
  logic                   load_done_q;
  logic                   load_err_q;

  logic        take;
  logic [15:0] count_d;
  logic [31:0] word_d;
  logic [15:0] word_cnt_d;
  logic        count_bad;

  // The 4th byte goes straight into the write data, so only three bytes need holding.
  always_comb begin
    take       = rx_valid && rx_ready_q;
    count_d    = {count_q[15:8], rx_data};
    word_d     = {asm_q, rx_data};
    word_cnt_d = word_cnt_q + 16'd1;
    count_bad  = (count_d == 16'd0) || ({1'b0, count_d} > 17'(IMEM_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR_HI;
            rx_ready_q <= 1'b1;
          end
        end
        S_HDR_HI: begin
          if (take) begin
            count_q[15:8] <= rx_data;
            state_q       <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (take) begin
            count_q <= count_d;
            if (count_bad) begin
              state_q    <= S_ERR;
              rx_ready_q <= 1'b0;
              load_err_q <= 1'b1;
            end else begin
              state_q     <= S_DATA;
              imem_addr_q <= '0;
              word_cnt_q  <= '0;
              byte_cnt_q  <= '0;
            end
          end
        end
        S_DATA: begin
          if (take) begin
            asm_q      <= word_d[23:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              rx_ready_q   <= 1'b0;
              imem_we_q    <= 1'b1;
              imem_wdata_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_cnt_d;
          if (word_cnt_d == count_q) begin
            state_q     <= S_DONE;
            core_rst_q  <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            state_q     <= S_DATA;
            imem_addr_q <= imem_addr_q + 1'b1;
            rx_ready_q  <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state_q     <= S_HDR_HI;
            rx_ready_q  <= 1'b1;
            core_rst_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader (depth 256 and depth 4 instances)
module tb_imem_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_v;
  logic [1:0]  rx_valid_v;
  logic [7:0]  rx_data;

  logic        rdy0, we0, crst0, done0, err0;
  logic [7:0]  addr0;
  logic [31:0] wd0;
  logic        rdy1, we1, crst1, done1, err1;
  logic [1:0]  addr1;
  logic [31:0] wd1;

  int          errors = 0;
  int          checks = 0;
  int          sel = 0;
  wr_t         exp0[$];
  wr_t         exp1[$];
  bit          exp_rel[2];
  bit          rel_arm[2];
  logic [31:0] img[$];

  always #5 clk = ~clk;

  imem_loader #(.IMEM_DEPTH(256)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .rx_valid(rx_valid_v[0]), .rx_data(rx_data),
    .rx_ready(rdy0), .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0),
    .core_rst(crst0), .load_done(done0), .load_err(err0)
  );

  imem_loader #(.IMEM_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .rx_valid(rx_valid_v[1]), .rx_data(rx_data),
    .rx_ready(rdy1), .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1),
    .core_rst(crst1), .load_done(done1), .load_err(err1)
  );

  function automatic logic cur_ready(); return (sel != 0) ? rdy1 : rdy0; endfunction
  function automatic logic cur_done();  return (sel != 0) ? done1 : done0; endfunction
  function automatic logic cur_err();   return (sel != 0) ? err1 : err0; endfunction
  function automatic logic cur_crst();  return (sel != 0) ? crst1 : crst0; endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the next expected write of that instance.
  task automatic mon(input int i, input logic we, input logic [7:0] a, input logic [31:0] d,
                     input logic rdy, input logic crst, input logic done);
    wr_t e;
    int  sz;
    if (rel_arm[i]) begin
      chk(!crst && done, "release_after_last_write", {30'd0, crst, done}, 32'h1);
      rel_arm[i] = 1'b0;
    end
    if (we === 1'b1) begin
      sz = (i == 0) ? exp0.size() : exp1.size();
      chk(sz != 0, "spurious_write_addr", {24'd0, a}, 32'd0);
      if (sz != 0) begin
        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
        chk(a == e.addr, "wr_addr", {24'd0, a}, {24'd0, e.addr});
        chk(d == e.data, "wr_data", d, e.data);
        chk(!rdy, "rx_ready_in_write", {31'd0, rdy}, 32'd0);
        chk(crst, "core_rst_in_write", {31'd0, crst}, 32'd1);
        if (sz == 1 && exp_rel[i]) begin
          rel_arm[i] = 1'b1;
          exp_rel[i] = 1'b0;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, we0, addr0, wd0, rdy0, crst0, done0);
    mon(1, we1, {6'd0, addr1}, wd1, rdy1, crst1, done1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit took;
    int budget;
    if (gaps) repeat ($urandom_range(2)) tick();
    rx_data = b;
    rx_valid_v[sel] = 1'b1;
    took = 1'b0;
    budget = 0;
    while (!took && budget < 50) begin
      took = cur_ready();
      tick();
      budget++;
    end
    rx_valid_v[sel] = 1'b0;
    chk(took, "byte_accept_timeout", {31'd0, took}, 32'd1);
  endtask

  task automatic pulse_start();
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    chk(cur_ready() == 1'b1, "start_rx_ready", {31'd0, cur_ready()}, 32'd1);
    chk(cur_crst() == 1'b1, "start_core_rst", {31'd0, cur_crst()}, 32'd1);
    chk(!cur_done() && !cur_err(), "start_flags_clear", {30'd0, cur_done(), cur_err()}, 32'd0);
  endtask

  task automatic push_exp(input int s, input logic [7:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    if (s == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back($urandom);
  endtask

  // Reference: a header 1..depth yields word i of img at address i, else error with no writes.
  task automatic load_image(input int s, input int n, input bit gaps);
    int          depth;
    bit          ok;
    int          budget;
    logic [15:0] nh;
    logic [31:0] w;
    sel = s;
    depth = (s != 0) ? 4 : 256;
    ok = (n != 0) && (n <= depth);
    nh = n[15:0];
    if (ok) for (int i = 0; i < n; i++) push_exp(s, i[7:0], img[i]);
    exp_rel[s] = ok;
    pulse_start();
    send_byte(nh[15:8], gaps);
    send_byte(nh[7:0], gaps);
    if (!ok) begin
      chk(cur_err() == 1'b1, "hdr_reject_err", {31'd0, cur_err()}, 32'd1);
      chk(cur_ready() == 1'b0, "hdr_reject_ready", {31'd0, cur_ready()}, 32'd0);
    end else begin
      for (int i = 0; i < n; i++) begin
        w = img[i];
        for (int b = 3; b >= 0; b--) send_byte(w[b*8 +: 8], gaps);
      end
    end
    budget = 0;
    while (!cur_done() && !cur_err() && budget < 20) begin
      tick();
      budget++;
    end
    repeat (2) tick();
    chk(cur_done() == ok, "load_done", {31'd0, cur_done()}, {31'd0, ok});
    chk(cur_err() == !ok, "load_err", {31'd0, cur_err()}, {31'd0, !ok});
    chk(cur_crst() == !ok, "core_rst_final", {31'd0, cur_crst()}, {31'd0, !ok});
    chk(((s == 0) ? exp0.size() : exp1.size()) == 0, "missing_writes",
        (s == 0) ? exp0.size() : exp1.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    rst = 1'b1;
    start_v = 2'b00;
    rx_valid_v = 2'b00;
    rx_data = 8'h00;

    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk({crst0, rdy0, we0, done0, err0} == 5'b10000, "reset_state_d0",
          {27'd0, crst0, rdy0, we0, done0, err0}, 32'h10);
      chk({crst1, rdy1, we1, done1, err1} == 5'b10000, "reset_state_d1",
          {27'd0, crst1, rdy1, we1, done1, err1}, 32'h10);
    end
    chk(addr0 == 8'd0 && wd0 == 32'd0, "reset_addr_data", wd0 | {24'd0, addr0}, 32'd0);

    img = '{32'h20080005, 32'hAC010004};
    load_image(0, 2, 1'b0);
    load_image(0, 2, 1'b1);

    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_img(n);
      load_image(0, n, $urandom_range(1) != 0);
    end

    img.delete();
    load_image(0, 0, 1'b0);
    load_image(0, 257, 1'b0);
    rand_img(1);
    load_image(0, 1, 1'b1);

    rand_img(4);
    load_image(1, 4, 1'b1);
    img.delete();
    load_image(1, 5, 1'b0);

    rand_img(256);
    load_image(0, 256, 1'b0);

    // Reset after two bytes of the second word of a 3-word image.
    sel = 0;
    w0 = $urandom;
    w1 = $urandom;
    exp_rel[0] = 1'b0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    push_exp(0, 8'd0, w0);
    for (int b = 3; b >= 0; b--) send_byte(w0[b*8 +: 8], 1'b0);
    send_byte(w1[31:24], 1'b0);
    send_byte(w1[23:16], 1'b0);
    rst = 1'b1;
    tick();
    chk({crst0, rdy0, we0, done0, err0} == 5'b10000, "midload_reset_state",
        {27'd0, crst0, rdy0, we0, done0, err0}, 32'h10);
    chk(addr0 == 8'd0 && wd0 == 32'd0, "midload_reset_addr_data", wd0 | {24'd0, addr0}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk(exp0.size() == 0, "midload_word0_written", exp0.size(), 32'd0);

    img = '{32'h00000000};
    load_image(0, 1, 1'b0);
    pulse_start();
    chk(done0 == 1'b0, "restart_clears_done", {31'd0, done0}, 32'd0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader: the write-side counterpart of the core's instruction-memory read port. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS instruction words, and writes them sequentially into instruction memory from word address 0. The core is held in reset while a load is in progress and released only after a complete, valid image has been written.

## Interface
**Parameters**
- IMEM_DEPTH, 256: instruction memory depth in 32-bit words.
- IMEM_ADDR_W, $clog2(IMEM_DEPTH): width of the word address.

**Ports**
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that arms a new load. Honoured only in IDLE, DONE or ERR.
- rx_valid, input, 1: byte valid from the source (UART receiver or testbench).
- rx_data, input, 8: byte payload.
- rx_ready, output, 1: loader can accept a byte.
- imem_we, output, 1: instruction memory write strobe.
- imem_addr, output, IMEM_ADDR_W: word address.
- imem_wdata, output, 32: instruction word.
- core_rst, output, 1: reset to the MIPS core, active-high.
- load_done, output, 1: image loaded and core released.
- load_err, output, 1: header rejected.

## Operation
- **Stream format:**
  - 2-byte word count N, high byte first.
  - Followed by N×4 bytes, each word sent MSB first (byte 0 → bits 31:24).
- **Transfer rule:** a byte transfers on any rising edge with rx_valid && rx_ready. rx_valid may drop at any time. The source must not change rx_data while rx_valid && !rx_ready.
- **States:**
  - IDLE: wait for start. → HDR_HI.
  - HDR_HI: accept byte into count[15:8]. → HDR_LO.
  - HDR_LO: accept byte into count[7:0].
    - If the full count is 0 or greater than IMEM_DEPTH → ERR.
    - Otherwise clear the word address and word counter, then → DATA.
  - DATA: accept bytes, shifting into a 32-bit assembly register. A 2-bit byte counter wraps 3→0. The 4th byte → WRITE.
  - WRITE: imem_we=1 for exactly one cycle, with imem_addr equal to the current word address and imem_wdata equal to the assembled word.
    - If words written including this one equal N → DONE.
    - Otherwise increment the address and → DATA.
  - DONE: core_rst=0, load_done=1. start → HDR_HI.
  - ERR: load_err=1, core_rst stays 1. start → HDR_HI.
- **rx_ready:** 1 only in HDR_HI, HDR_LO and DATA. It is 0 in IDLE, WRITE, DONE and ERR. Bytes offered while rx_ready=0 are not consumed.
- **core_rst:** 1 in every state except DONE.
- **Outputs:** all are registered decodes of state, with no combinational path from rx_valid.
- **Restart:** a start taken from DONE reasserts core_rst on the next edge, clears load_done, and reloads from address 0.
- **Ignored start:** start in HDR_HI, HDR_LO, DATA or WRITE is ignored. The load in progress continues.
- **Count width:** the count is 16 bits and is compared against IMEM_DEPTH zero-extended.
- **Address width:** the word address never wraps, because N ≤ IMEM_DEPTH guarantees the last address is IMEM_DEPTH−1.

## Timing
- **Reset values:**
  - State IDLE.
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - core_rst=1, load_done=0, load_err=0.
  - Count, byte counter and word counter all cleared.
- **Start latency:** start sampled at edge t gives rx_ready=1 from t+1.
- **Write latency:** the 4th byte of a word accepted at edge k gives imem_we=1 during cycle k..k+1 (visible after edge k). rx_ready=0 in that same cycle. rx_ready returns to 1 after edge k+1 if more words remain.
- **Release latency:** for the last word, DONE is entered at edge k+1, so core_rst=0 and load_done=1 from k+1.
- **Throughput:** peak rate is 4 bytes per 5 cycles.
- **Header rejection:** the byte completing an invalid header, accepted at edge h, gives load_err=1 and rx_ready=0 from h+1. No imem_we is ever issued for a rejected image.
- **Reset mid-load:** rst during any state returns every output to its reset value on that edge. A partially written image stays in memory but the core remains in reset. No write strobe may occur in the cycle after rst.

## Test plan
- **Reset values:** hold rst for 3 cycles, then release with no start. Required: core_rst=1, rx_ready=0, imem_we=0, load_done=0, load_err=0, stable for 20 cycles.
- **Two-word image:** start, then send 00 02 20 08 00 05 AC 01 00 04 back-to-back. Required:
  - Exactly two imem_we pulses: addr 0 with 0x20080005, then addr 1 with 0xAC010004.
  - core_rst falls and load_done rises on the edge after the second write cycle.
- **Backpressure and gaps:** same image with rx_valid toggled randomly (about 50%) and bytes also offered during WRITE. Required: identical writes, no byte lost or duplicated, rx_ready=0 during each write cycle.
- **Header errors:**
  - Header 00 00 → load_err=1, no writes.
  - With IMEM_DEPTH=256, header 01 01 → load_err=1, no writes, core_rst=1.
  - A subsequent start followed by a valid 1-word image → load_err clears and load_done=1.
- **Boundary:** with IMEM_DEPTH=4, load N=4. Required: writes to addresses 0,1,2,3 only, then DONE.
- **Reset mid-load and restart:** assert rst after the 2nd byte of word 1, then start and load a 1-word image 0x00000000. Required: the first write is addr 0, and there are no spurious writes. Afterwards, start from DONE reasserts core_rst on the next edge.
